// File: rtl/rv32ima_pkg.sv
// Shared RV32 load/store definitions: access-width codes, controller state
// encoding and the byte-enable helper used by the RAM access controller.
package rv32ima_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } ram_ctrl_state_t;

    // Lane mask for an access of the given width at byte offset off.
    function automatic logic [3:0] byteen_f(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Unsigned widths exist only for loads.
    function automatic logic funct3_legal_f(input logic [2:0] funct3, input logic wen);
        logic ok;
        case (funct3)
            LSU_B, LSU_H, LSU_W: ok = 1'b1;
            LSU_BU, LSU_HU:      ok = !wen;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane steering: replicates store data across byte lanes and
// shifts/extends raw RAM words into right-justified load data.
module lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  store_size,
    input  logic [31:0] store_raw,
    output logic [31:0] store_lanes,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_off,
    input  logic [31:0] load_raw,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the output latched.
        store_lanes = store_raw;
        case (store_size)
            2'b00:   store_lanes = {4{store_raw[7:0]}};
            2'b01:   store_lanes = {2{store_raw[15:0]}};
            default: store_lanes = store_raw;
        endcase
    end

    assign shifted = load_raw >> {load_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (load_funct3)
            LSU_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  load_data = {24'd0, shifted[7:0]};
            LSU_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-outstanding RV32 load/store front-end for a synchronous RAM:
// validates the request, drives the RAM port, waits out read latency, responds.
module ram_access_ctrl
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_store,
    output logic              ram_wen,
    output logic [3:0]        ram_byteen,
    input  logic [31:0]       ram_load
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    ram_ctrl_state_t  state;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_wen;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_off;

    logic        accept;
    logic        err_funct3;
    logic        err_align;
    logic        err_range;
    logic        req_err;
    logic [31:0] store_lanes;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        err_funct3 = !funct3_legal_f(req_funct3, req_wen);
        err_align  = 1'b0;
        case (req_funct3)
            LSU_H, LSU_HU: err_align = req_addr[0];
            LSU_W:         err_align = (req_addr[1:0] != 2'b00);
            default:       err_align = 1'b0;
        endcase
        err_range = ((req_addr >> (ADDR_W + 2)) != 32'd0);
        req_err   = err_funct3 || err_align || err_range;
    end

    lane_align u_lane_align (
        .store_size  (req_funct3[1:0]),
        .store_raw   (req_wdata),
        .store_lanes (store_lanes),
        .load_funct3 (lat_funct3),
        .load_off    (lat_off),
        .load_raw    (ram_load),
        .load_data   (load_data)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            lat_wen    <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            ram_addr   <= '0;
            ram_store  <= 32'd0;
            ram_wen    <= 1'b0;
            ram_byteen <= 4'b0000;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_wen    <= req_wen;
                        lat_funct3 <= req_funct3;
                        lat_off    <= req_addr[1:0];
                        ram_addr   <= req_addr[ADDR_W+1:2];
                        lat_cnt    <= CNT_W'(RD_LAT - 1);
                        if (req_err) begin
                            // Rejected requests skip the RAM entirely.
                            state      <= RESP;
                            ram_byteen <= 4'b0000;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state      <= ACCESS;
                            ram_byteen <= byteen_f(req_funct3, req_addr[1:0]);
                            ram_wen    <= req_wen;
                            if (req_wen) begin
                                ram_store <= store_lanes;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (lat_wen) begin
                        state      <= RESP;
                        ram_wen    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end else if (lat_cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: byte-addressed reference memory,
// directed scenarios plus randomized load/store traffic.
module tb_ram_access_ctrl;
    import rv32ima_pkg::*;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;
    localparam int WORDS  = 1 << ADDR_W;
    localparam int BYTES  = 4 * WORDS;

    logic              clk = 1'b0;
    logic              nrst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_store;
    logic              ram_wen;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_load;

    int n_checks = 0;
    int n_bad    = 0;

    bit [31:0] ram_mem [WORDS];
    bit [7:0]  ref_mem [BYTES];
    logic [31:0] ram_q = 32'd0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_store  (ram_store),
        .ram_wen    (ram_wen),
        .ram_byteen (ram_byteen),
        .ram_load   (ram_load)
    );

    // RAM with registered q; together with the DUT's registered address this is RD_LAT = 2.
    always @(posedge clk) begin
        if (ram_wen === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_byteen[k]) ram_mem[ram_addr][8*k +: 8] <= ram_store[8*k +: 8];
            end
        end
        ram_q <= ram_mem[ram_addr];
    end
    assign ram_load = ram_q;

    // Reference: what the request should do to a flat byte memory.
    task automatic ref_model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                             output logic [3:0] be, output logic [31:0] st, output int lat);
        int size;
        bit legal;
        logic [31:0] v;
        legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(wen && f3[2]);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        err   = !legal || (addr % size != 0) || (addr >= BYTES);
        rdata = 32'd0;
        be    = 4'b0000;
        st    = 32'd0;
        lat   = 0;
        if (!err) begin
            be = (size == 4) ? 4'hF : (((size == 2) ? 4'h3 : 4'h1) << (addr % 4));
            st = (size == 1) ? wdata[7:0] * 32'h01010101 :
                 (size == 2) ? wdata[15:0] * 32'h00010001 : wdata;
            if (wen) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
                lat = 1;
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
                if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
                if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
                rdata = v;
                lat   = RD_LAT;
            end
        end
    endtask

    // One full request/response; entered and left at #1 after a rising edge.
    task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input string tag);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_st;
        logic [3:0]  exp_be;
        int          exp_lat;
        int          edges;
        int          wen_cycles;
        ref_model(wen, f3, addr, wdata, exp_err, exp_rdata, exp_be, exp_st, exp_lat);

        n_checks++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_idle: req_ready=%b want 1", tag, req_ready);
        end
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        // Junk on the request bus while busy must be ignored.
        req_valid  = 1'($urandom_range(0, 1));
        req_wen    = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        edges      = 0;
        wen_cycles = 0;
        while (resp_valid !== 1'b1 && edges < 20) begin
            if (edges == 0 && !exp_err) begin
                n_checks++;
                if (ram_addr !== ADDR_W'(addr >> 2) || ram_byteen !== exp_be ||
                    (wen && ram_store !== exp_st)) begin
                    n_bad++;
                    $display("FAIL %s ram_port: addr=%h be=%b store=%h want addr=%h be=%b store=%h",
                             tag, ram_addr, ram_byteen, ram_store, ADDR_W'(addr >> 2), exp_be, exp_st);
                end
            end
            if (ram_wen !== 1'b0) wen_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        if (ram_wen !== 1'b0) wen_cycles++;

        n_checks++;
        if (edges != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: resp_valid after %0d edges want %0d", tag, edges, exp_lat);
        end
        n_checks++;
        if (wen_cycles != ((wen && !exp_err) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s wen_cycles: got %0d want %0d", tag, wen_cycles, (wen && !exp_err) ? 1 : 0);
        end
        n_checks++;
        if (resp_err !== exp_err || resp_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s resp: err=%b rdata=%h want err=%b rdata=%h",
                     tag, resp_err, resp_rdata, exp_err, exp_rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rdata ||
                req_ready !== 1'b0 || ram_wen !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d: valid=%b err=%b rdata=%h req_ready=%b wen=%b want 1 %b %h 0 0",
                         tag, i, resp_valid, resp_err, resp_rdata, req_ready, ram_wen, exp_err, exp_rdata);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b want 0 1", tag, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        #3;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 || ram_wen !== 1'b0 ||
            ram_addr !== '0 || ram_store !== 32'd0 || ram_byteen !== 4'b0000 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b err=%b rdata=%h wen=%b addr=%h store=%h be=%b ready=%b",
                     resp_valid, resp_err, resp_rdata, ram_wen, ram_addr, ram_store, ram_byteen, req_ready);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_word();
        do_req(1'b1, LSU_W, 32'h10, 32'hDEADBEEF, 0, "sw_10");
        do_req(1'b0, LSU_W, 32'h10, 32'h0, 0, "lw_10");
    endtask

    task automatic test_byte();
        do_req(1'b1, LSU_B,  32'h13, 32'h00000080, 0, "sb_13");
        do_req(1'b0, LSU_B,  32'h13, 32'h0, 0, "lb_13");
        do_req(1'b0, LSU_BU, 32'h13, 32'h0, 0, "lbu_13");
    endtask

    task automatic test_errors();
        do_req(1'b0, LSU_H,  32'h11, 32'h0, 0, "lh_mis");
        do_req(1'b0, LSU_W,  32'h12, 32'h0, 0, "lw_mis");
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 0, "f3_011");
        do_req(1'b1, LSU_BU, 32'h00, 32'h55, 0, "sbu_ill");
        do_req(1'b0, 3'b111, 32'h00, 32'h0, 0, "f3_111");
        do_req(1'b1, LSU_B,  32'(1) << (ADDR_W + 2), 32'h77, 0, "sb_range");
    endtask

    task automatic test_range_half();
        do_req(1'b0, LSU_W,  32'(1) << (ADDR_W + 2), 32'h0, 0, "lw_range");
        do_req(1'b0, LSU_W,  32'(BYTES - 4), 32'h0, 0, "lw_top");
        do_req(1'b1, LSU_H,  32'h2, 32'h00001234, 0, "sh_2");
        do_req(1'b0, LSU_HU, 32'h2, 32'h0, 0, "lhu_2");
        do_req(1'b1, LSU_H,  32'h6, 32'hABCD9876, 0, "sh_6");
        do_req(1'b0, LSU_H,  32'h6, 32'h0, 0, "lh_6");
    endtask

    task automatic test_backpressure();
        do_req(1'b0, LSU_W, 32'h10, 32'h0, 5, "lw_hold");
        do_req(1'b1, LSU_B, 32'h21, 32'hA5, 5, "sb_hold");
        do_req(1'b0, 3'b110, 32'h0, 32'h0, 5, "err_hold");
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_funct3 = LSU_W;
        req_addr   = 32'h10;
        req_wdata  = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: req_ready=%b want 0", req_ready);
        end
        nrst = 1'b0;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
            ram_addr !== '0 || ram_byteen !== 4'b0000 || ram_store !== 32'd0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_load: wen=%b valid=%b err=%b rdata=%h addr=%h be=%b ready=%b",
                     ram_wen, resp_valid, resp_err, resp_rdata, ram_addr, ram_byteen, req_ready);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_mid_noresp: resp_valid seen %0d cycles want 0", seen);
        end

        // Store interrupted while ram_wen is high: write must not land.
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_funct3 = LSU_W;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (ram_wen !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_store_wen: ram_wen=%b want 1", ram_wen);
        end
        nrst = 1'b0;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_store_drop: ram_wen=%b want 0", ram_wen);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, LSU_W, 32'h40, 32'h0, 0, "lw_after_rst");
        do_req(1'b0, LSU_W, 32'h10, 32'h0, 1, "lw_10_again");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] addr;
        int          pick;
        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1:    f3 = LSU_B;
                2:       f3 = LSU_BU;
                3:       f3 = LSU_H;
                4:       f3 = LSU_HU;
                5, 6, 7: f3 = LSU_W;
                default: f3 = 3'($urandom);
            endcase
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) addr = addr & ((f3[1:0] == 2'b10) ? 32'hFFFFFFFC :
                                                          (f3[1:0] == 2'b01) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
            if ($urandom_range(0, 19) == 0) addr = $urandom;
            do_req(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_range_half();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
